// File: rtl/core_pkg.sv
// Shared types for the multicycle RV32I core: sequencer states, opcode values
// and the coarse instruction classes the sequencer steps on.
package core_pkg;

  // Sequencer state encoding; values are visible on the State port.
  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    TRAP   = 3'd7
  } state_t;

  // Coarse instruction classes derived from IR[6:0].
  typedef enum logic [2:0] {
    ALU,
    UPPER,
    LOAD,
    STORE,
    BRANCH,
    JUMP,
    ILLEGAL
  } iclass_t;

  localparam int unsigned OPCODE_W = 7;

  localparam logic [OPCODE_W-1:0] OP_ALU    = 7'b0110011;
  localparam logic [OPCODE_W-1:0] OP_ALUI   = 7'b0010011;
  localparam logic [OPCODE_W-1:0] OP_BRANCH = 7'b1100011;
  localparam logic [OPCODE_W-1:0] OP_STORE  = 7'b0100011;
  localparam logic [OPCODE_W-1:0] OP_JAL    = 7'b1101111;
  localparam logic [OPCODE_W-1:0] OP_JALR   = 7'b1100111;
  localparam logic [OPCODE_W-1:0] OP_LUI    = 7'b0110111;
  localparam logic [OPCODE_W-1:0] OP_AUIPC  = 7'b0010111;
  localparam logic [OPCODE_W-1:0] OP_LOAD   = 7'b0000011;

endpackage

// File: rtl/opcode_classifier.sv
// Combinational opcode -> instruction class map. Shared with the opcode decoder.
//   opcode_i  : IR[6:0]
//   iclass_o  : instruction class, ILLEGAL for any unlisted opcode
module opcode_classifier
  import core_pkg::*;
(
  input  logic [OPCODE_W-1:0] opcode_i,
  output iclass_t             iclass_o
);

  always_comb begin
    iclass_o = ILLEGAL;
    case (opcode_i)
      OP_ALU, OP_ALUI:  iclass_o = ALU;
      OP_LUI, OP_AUIPC: iclass_o = UPPER;
      OP_LOAD:          iclass_o = LOAD;
      OP_STORE:         iclass_o = STORE;
      OP_BRANCH:        iclass_o = BRANCH;
      OP_JAL, OP_JALR:  iclass_o = JUMP;
      default:          iclass_o = ILLEGAL;
    endcase
  end

endmodule

// File: rtl/multicycle_sequencer.sv
// Multicycle sequencer: steps each instruction through FETCH/DECODE/EXEC/MEM/WB,
// issues PC/IR/register-file/memory strobes and arbitrates the unified memory
// port between fetch and load/store.
//   clk, rst      : clock, asynchronous active-high reset
//   OpCode        : IR[6:0], valid from DECODE onward
//   BrTaken       : branch condition, used in EXEC
//   MemAck        : memory access done (only meaningful while MemReq=1)
//   PCWr/PCSrc    : PC load strobe and source (0=PC+4, 1=ALUOut)
//   IRWr          : instruction register load
//   MemReq/MemWe/MemAddrSrc : memory request, store qualifier, address source
//   RUWr          : register-file write
//   Retire        : one-cycle pulse per completed instruction
//   Trap          : sticky fault (illegal opcode or memory timeout)
//   State, RetCnt : current state, retired-instruction count
module multicycle_sequencer
  import core_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned RET_W       = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [OPCODE_W-1:0] OpCode,
  input  logic                BrTaken,
  input  logic                MemAck,
  output logic                PCWr,
  output logic                PCSrc,
  output logic                IRWr,
  output logic                MemReq,
  output logic                MemWe,
  output logic                MemAddrSrc,
  output logic                RUWr,
  output logic                Retire,
  output logic                Trap,
  output logic [2:0]          State,
  output logic [RET_W-1:0]    RetCnt
);

  localparam int unsigned TMO_W = $clog2(MEM_TIMEOUT + 1);

  state_t             state_q, state_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;
  logic [RET_W-1:0]   ret_q;
  logic               tmo_hit;
  iclass_t            iclass;

  opcode_classifier u_cls (
    .opcode_i (OpCode),
    .iclass_o (iclass)
  );

  // The current wait cycle is the MEM_TIMEOUT-th unacknowledged request cycle.
  assign tmo_hit = (tmo_q == TMO_W'(MEM_TIMEOUT - 1));

  // Next state and strobe decode; strobes are forced low while rst is held.
  always_comb begin
    state_d    = state_q;
    PCWr       = 1'b0;
    PCSrc      = 1'b0;
    IRWr       = 1'b0;
    MemReq     = 1'b0;
    MemWe      = 1'b0;
    MemAddrSrc = 1'b0;
    RUWr       = 1'b0;
    Retire     = 1'b0;
    case (state_q)
      FETCH: begin
        MemReq = 1'b1;
        if (MemAck) begin
          IRWr    = 1'b1;
          state_d = DECODE;
        end else if (tmo_hit) begin
          state_d = TRAP;
        end
      end
      DECODE: begin
        state_d = (iclass == ILLEGAL) ? TRAP : EXEC;
      end
      EXEC: begin
        case (iclass)
          BRANCH: begin
            PCWr    = 1'b1;
            PCSrc   = BrTaken;
            Retire  = 1'b1;
            state_d = FETCH;
          end
          LOAD, STORE: state_d = MEM;
          ILLEGAL:     state_d = TRAP;
          default:     state_d = WB;
        endcase
      end
      MEM: begin
        MemReq     = 1'b1;
        MemAddrSrc = 1'b1;
        MemWe      = (iclass == STORE);
        if (MemAck) begin
          if (iclass == STORE) begin
            PCWr    = 1'b1;
            Retire  = 1'b1;
            state_d = FETCH;
          end else begin
            state_d = WB;
          end
        end else if (tmo_hit) begin
          state_d = TRAP;
        end
      end
      WB: begin
        RUWr    = 1'b1;
        PCWr    = 1'b1;
        PCSrc   = (iclass == JUMP);
        Retire  = 1'b1;
        state_d = FETCH;
      end
      TRAP:    state_d = TRAP;
      default: state_d = TRAP;
    endcase
    if (rst) begin
      PCWr       = 1'b0;
      PCSrc      = 1'b0;
      IRWr       = 1'b0;
      MemReq     = 1'b0;
      MemWe      = 1'b0;
      MemAddrSrc = 1'b0;
      RUWr       = 1'b0;
      Retire     = 1'b0;
    end
  end

  // Wait counter runs only across consecutive unacknowledged cycles in one state.
  always_comb begin
    tmo_d = '0;
    if (MemReq && !MemAck && (state_d == state_q)) tmo_d = tmo_q + TMO_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FETCH;
      tmo_q   <= '0;
      ret_q   <= '0;
    end else begin
      state_q <= state_d;
      tmo_q   <= tmo_d;
      if (Retire) ret_q <= ret_q + RET_W'(1);
    end
  end

  assign Trap   = (state_q == TRAP);
  assign State  = state_q;
  assign RetCnt = ret_q;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Directed bench for multicycle_sequencer: walks ADD, LW, SW, BEQ, JAL, an
// illegal opcode and memory-timeout cases, checking State/strobes every cycle.
module tb_multicycle_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic [6:0]  OpCode;
  logic        BrTaken;
  logic        MemAck;
  logic        PCWr, PCSrc, IRWr, MemReq, MemWe, MemAddrSrc, RUWr, Retire, Trap;
  logic [2:0]  State;
  logic [31:0] RetCnt;
  logic [8:0]  strb;

  int total = 0;
  int bad   = 0;

  localparam logic [8:0] NONE  = 9'h000;
  localparam logic [8:0] PCWR  = 9'h100;
  localparam logic [8:0] PCSRC = 9'h080;
  localparam logic [8:0] IRWR  = 9'h040;
  localparam logic [8:0] MREQ  = 9'h020;
  localparam logic [8:0] MWE   = 9'h010;
  localparam logic [8:0] MADDR = 9'h008;
  localparam logic [8:0] RUWR  = 9'h004;
  localparam logic [8:0] RET   = 9'h002;
  localparam logic [8:0] TRP   = 9'h001;

  multicycle_sequencer #(.MEM_TIMEOUT(16), .RET_W(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .OpCode     (OpCode),
    .BrTaken    (BrTaken),
    .MemAck     (MemAck),
    .PCWr       (PCWr),
    .PCSrc      (PCSrc),
    .IRWr       (IRWr),
    .MemReq     (MemReq),
    .MemWe      (MemWe),
    .MemAddrSrc (MemAddrSrc),
    .RUWr       (RUWr),
    .Retire     (Retire),
    .Trap       (Trap),
    .State      (State),
    .RetCnt     (RetCnt)
  );

  always #5 clk = ~clk;

  assign strb = {PCWr, PCSrc, IRWr, MemReq, MemWe, MemAddrSrc, RUWr, Retire, Trap};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive MemAck, check state/strobes mid-cycle, advance.
  task automatic step(input string tag, input logic ack, input logic [8:0] exp_s,
                      input logic [2:0] exp_st);
    MemAck = ack;
    @(negedge clk);
    chk({tag, "_state"}, 32'(State), 32'(exp_st));
    chk({tag, "_strb"},  32'(strb),  32'(exp_s));
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; OpCode = 7'b0110011; BrTaken = 1'b0; MemAck = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_state",  32'(State),  32'd0);
    chk("rst_strb",   32'(strb),   32'(NONE));
    chk("rst_retcnt", RetCnt,      32'd0);
    rst = 1'b0;

    // ADD
    OpCode = 7'b0110011;
    step("add_f",  1'b1, MREQ | IRWR, 3'd0);
    step("add_d",  1'b0, NONE, 3'd1);
    step("add_e",  1'b0, NONE, 3'd2);
    step("add_wb", 1'b0, RUWR | PCWR | RET, 3'd4);
    chk("add_retcnt", RetCnt, 32'd1);

    // LW with two wait cycles on each access
    OpCode = 7'b0000011;
    step("lw_f0", 1'b0, MREQ, 3'd0);
    step("lw_f1", 1'b0, MREQ, 3'd0);
    step("lw_f2", 1'b1, MREQ | IRWR, 3'd0);
    step("lw_d",  1'b0, NONE, 3'd1);
    step("lw_e",  1'b0, NONE, 3'd2);
    step("lw_m0", 1'b0, MREQ | MADDR, 3'd3);
    step("lw_m1", 1'b0, MREQ | MADDR, 3'd3);
    step("lw_m2", 1'b1, MREQ | MADDR, 3'd3);
    step("lw_wb", 1'b0, RUWR | PCWR | RET, 3'd4);
    chk("lw_retcnt", RetCnt, 32'd2);

    // SW
    OpCode = 7'b0100011;
    step("sw_f", 1'b1, MREQ | IRWR, 3'd0);
    step("sw_d", 1'b0, NONE, 3'd1);
    step("sw_e", 1'b0, NONE, 3'd2);
    step("sw_m", 1'b1, MREQ | MADDR | MWE | PCWR | RET, 3'd3);
    chk("sw_retcnt", RetCnt, 32'd3);

    // BEQ taken then not taken
    OpCode = 7'b1100011; BrTaken = 1'b1;
    step("beq1_f", 1'b1, MREQ | IRWR, 3'd0);
    step("beq1_d", 1'b0, NONE, 3'd1);
    step("beq1_e", 1'b0, PCWR | PCSRC | RET, 3'd2);
    BrTaken = 1'b0;
    step("beq0_f", 1'b1, MREQ | IRWR, 3'd0);
    step("beq0_d", 1'b0, NONE, 3'd1);
    step("beq0_e", 1'b0, PCWR | RET, 3'd2);
    chk("beq_retcnt", RetCnt, 32'd5);

    // JAL writes back and loads the target
    OpCode = 7'b1101111;
    step("jal_f",  1'b1, MREQ | IRWR, 3'd0);
    step("jal_d",  1'b0, NONE, 3'd1);
    step("jal_e",  1'b0, NONE, 3'd2);
    step("jal_wb", 1'b0, RUWR | PCWR | PCSRC | RET, 3'd4);
    chk("jal_retcnt", RetCnt, 32'd6);

    // Illegal opcode traps; MemAck ignored; reset recovers
    OpCode = 7'b1111111;
    step("ill_f",  1'b1, MREQ | IRWR, 3'd0);
    step("ill_d",  1'b0, NONE, 3'd1);
    step("ill_t0", 1'b1, TRP, 3'd7);
    step("ill_t1", 1'b0, TRP, 3'd7);
    step("ill_t2", 1'b1, TRP, 3'd7);
    chk("ill_retcnt", RetCnt, 32'd6);
    rst = 1'b1; MemAck = 1'b0;
    #1;
    chk("ill_rst_state",  32'(State), 32'd0);
    chk("ill_rst_strb",   32'(strb),  32'(NONE));
    chk("ill_rst_retcnt", RetCnt,     32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Fetch timeout: 16 unacknowledged request cycles then TRAP
    for (int i = 0; i < 16; i++) step("tmo_f", 1'b0, MREQ, 3'd0);
    step("tmo_trap", 1'b0, TRP, 3'd7);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;

    // Ack arriving on the 16th request cycle wins over the timeout
    OpCode = 7'b0000011;
    for (int i = 0; i < 15; i++) step("ack16_f", 1'b0, MREQ, 3'd0);
    step("ack16_f15", 1'b1, MREQ | IRWR, 3'd0);
    step("ack16_d",   1'b0, NONE, 3'd1);
    step("ack16_e",   1'b0, NONE, 3'd2);
    step("ack16_m0",  1'b0, MREQ | MADDR, 3'd3);

    // Reset in the middle of a load access drops every strobe at once
    MemAck = 1'b1;
    rst = 1'b1;
    #1;
    chk("midmem_rst_state", 32'(State), 32'd0);
    chk("midmem_rst_strb",  32'(strb),  32'(NONE));
    chk("midmem_rst_trap",  32'(Trap),  32'd0);
    @(posedge clk); #1;
    MemAck = 1'b0;
    rst = 1'b0;
    step("post_rst_f", 1'b0, MREQ, 3'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
